nic3_pwr_seq: RTL and testbench
===============================

// Module: nic3_pwr_seq
// PURPOSE
//  Power-up/power-down sequencer for the OCP NIC3 slot rails. Steps 3 rail enables in order,
//  checks each rail's power-good within a timeout, inserts inter-rail delays, then releases PERST#.
//  Owns one step timer, reused for every delay and timeout. Sits between board power control
//  and the slot rail/PERST pins.
// PARAMETERS
//  T_PG_TMO    16'd2000   max clk_in cycles from en_out[i] rise to pg_in[i] high
//  T_ON_DLY    16'd500    cycles from pg_in[i] high to en_out[i+1] rise
//  T_PERST_DLY 16'd10000  cycles from pg_in[2] high to perst_n_out release
//  T_OFF_DLY   16'd200    cycles between successive rail drops on power-down
// PORTS
//  clk_in        in   1  system clock
//  iRst_n        in   1  asynchronous, active-low reset
//  pwr_req       in   1  1 = power slot on; 0 = power off (level)
//  pg_in         in   3  rail power-good, already synchronised to clk_in
//  en_out        out  3  rail enables; bit i = rail i
//  perst_n_out   out  1  PCIe PERST#, active low
//  pwr_ok        out  1  1 only in ON
//  fault         out  1  1 only in FAULT
//  fault_step    out  2  index of the rail that faulted; held until the next fault or reset
//  state_out     out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset (async): state=OFF, step=0, en_out=0, perst_n_out=0, pwr_ok=0, fault=0, fault_step=0.
//  All outputs are registered; they change on the clock after the state transition.
//  Timer: cleared on every state or step change. Expires on the D-th clock after entry (D=0 acts as 1).
//  States:
//   OFF      -> PG_WAIT, step=0, when pwr_req=1
//   PG_WAIT  en_out[step] set. pg_in[step]=1 -> ON_DLY, or PERST_DLY when step=2.
//            Timer T_PG_TMO expires first -> FAULT.
//   ON_DLY   Timer T_ON_DLY expires -> PG_WAIT with step+1.
//   PERST_DLY Timer T_PERST_DLY expires -> ON, perst_n_out=1.
//   ON       Holds. pwr_req=0 -> OFF_SEQ.
//   OFF_SEQ  perst_n_out=0 on entry. Clears the highest set en_out bit, then waits T_OFF_DLY
//            before clearing the next. All bits 0 and timer expired -> OFF.
//   FAULT    en_out=0, perst_n_out=0, fault=1, fault_step=step. Exit depends on the macro.
//  Rail-loss fault: in any state except OFF, OFF_SEQ and FAULT, any pg_in[j]=0 with j<step
//   (rail already good) -> FAULT. In ON, all three rails are checked.
//   fault_step = lowest such j.
//  Simultaneous events: fault detection has priority over pwr_req=0.
//   pwr_req=0 in PG_WAIT/ON_DLY/PERST_DLY -> OFF_SEQ. Only rails already enabled are sequenced off.
//  pwr_req=1 during OFF_SEQ is ignored; power-down completes, then OFF restarts on the next clock.
//  pg_in[step] already 1 on PG_WAIT entry: accepted on the first PG_WAIT cycle.
//  Step counter is 2 bits and saturates at 2; it never wraps.
// CONFIGURATION
//  NIC3_PWRSEQ_FAULT_LATCH_EN defined: FAULT is sticky; only iRst_n leaves it.
//  Not defined: FAULT -> OFF once pwr_req=0 is sampled. fault clears. fault_step is kept.
// STRUCTURE
//  Package nic3_pwr_seq_pkg: state encodings (OFF=0, PG_WAIT=1, ON_DLY=2, PERST_DLY=3, ON=4,
//   OFF_SEQ=5, FAULT=6), NUM_RAILS=3, timer width 16.
//  One sub-module, seq_step_timer: 16-bit counter with sync clear, load value and
//   registered expire flag. The controller muxes the load value per state.
// TESTING (bench params: T_PG_TMO=20, T_ON_DLY=10, T_PERST_DLY=50, T_OFF_DLY=5)
//  1. pwr_req=1; each pg_in[i] rises 3 cycles after en_out[i].
//     -> en_out rises 001/011/111, gaps 10 cycles after pg. perst_n_out=1 50 cycles after pg[2].
//     -> pwr_ok=1.
//  2. From ON, pwr_req=0 -> perst_n_out=0; en_out steps 111->011->001->000, 5 cycles apart.
//     -> state_out=OFF.
//  3. pg_in[1] never rises -> FAULT 20 cycles after en_out[1]; fault=1, fault_step=1, en_out=000.
//     With the macro, pwr_req toggling does not leave FAULT. Without it, pwr_req=0 -> OFF.
//  4. In ON, drop pg_in[0] for 1 cycle -> FAULT, fault_step=0, en_out=000, perst_n_out=0.
//  5. pwr_req=0 while in ON_DLY at step 1 -> OFF_SEQ; en_out 011->001->000 at 5-cycle spacing.
//     pwr_req=1 mid-sequence -> full power-down first, then a fresh power-up.
//  6. iRst_n low in PERST_DLY -> all outputs 0 asynchronously. After release with pwr_req=1,
//     the sequence restarts at step 0.

Source files
------------

// File: rtl/nic3_pwr_seq_pkg.sv
// Shared types and helpers for the NIC3 slot power sequencer.
// State encodings are fixed because state_out exposes them for debug.
package nic3_pwr_seq_pkg;

    localparam int NUM_RAILS = 3;
    localparam int TMR_W     = 16;
    localparam int STEP_W    = 2;

    localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] RAIL0     = NUM_RAILS'(1);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PG_WAIT   = 3'd1,
        ST_ON_DLY    = 3'd2,
        ST_PERST_DLY = 3'd3,
        ST_ON        = 3'd4,
        ST_OFF_SEQ   = 3'd5,
        ST_FAULT     = 3'd6
    } seq_state_e;

    // Rails go down in reverse order: clear only the highest enabled one.
    function automatic logic [NUM_RAILS-1:0] drop_top_rail(input logic [NUM_RAILS-1:0] en);
        logic [NUM_RAILS-1:0] r;
        logic                 done;
        r    = en;
        done = 1'b0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (!done && r[i]) begin
                r[i] = 1'b0;
                done = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [STEP_W-1:0] lowest_set(input logic [NUM_RAILS-1:0] v);
        logic [STEP_W-1:0] idx;
        idx = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (v[i]) idx = STEP_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nic3_pwr_seq_timer.sv
// Shared step timer: down-counter reloaded on clear, expire flag set on terminal count.
// A load of D expires D clocks after the clear (D=0 behaves as 1).
module seq_step_timer
    import nic3_pwr_seq_pkg::*;
(
    input  logic             clk_in,
    input  logic             iRst_n,
    input  logic             clr_i,
    input  logic [TMR_W-1:0] load_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             exp_q, exp_d;

    always_comb begin
        cnt_d = cnt_q;
        exp_d = exp_q;
        if (clr_i) begin
            cnt_d = (load_i == '0) ? '0 : load_i - TMR_W'(1);
            exp_d = (load_i <= TMR_W'(1));
        end else begin
            if (cnt_q != '0) cnt_d = cnt_q - TMR_W'(1);
            exp_d = (cnt_q <= TMR_W'(1));
        end
    end

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end

    assign expired_o = exp_q;

endmodule

// File: rtl/nic3_pwr_seq.sv
// OCP NIC3 slot power sequencer: rail enables in order, power-good timeouts, PERST# release.
// Define NIC3_PWRSEQ_FAULT_LATCH_EN to make FAULT sticky until iRst_n.
//
// state     | meaning
// OFF       | all rails off, waiting for pwr_req
// PG_WAIT   | rail[step] enabled, waiting for its power-good
// ON_DLY    | settle delay before enabling the next rail
// PERST_DLY | all rails good, holding PERST# before release
// ON        | slot powered, PERST# released
// OFF_SEQ   | dropping enabled rails highest-first
// FAULT     | rails off, fault_step identifies the rail
module nic3_pwr_seq
    import nic3_pwr_seq_pkg::*;
#(
    parameter logic [TMR_W-1:0] T_PG_TMO    = 16'd2000,
    parameter logic [TMR_W-1:0] T_ON_DLY    = 16'd500,
    parameter logic [TMR_W-1:0] T_PERST_DLY = 16'd10000,
    parameter logic [TMR_W-1:0] T_OFF_DLY   = 16'd200
) (
    input  logic                 clk_in,
    input  logic                 iRst_n,
    input  logic                 pwr_req,
    input  logic [NUM_RAILS-1:0] pg_in,
    output logic [NUM_RAILS-1:0] en_out,
    output logic                 perst_n_out,
    output logic                 pwr_ok,
    output logic                 fault,
    output logic [STEP_W-1:0]    fault_step,
    output logic [2:0]           state_out
);

    seq_state_e           state_q, state_d;
    logic [STEP_W-1:0]    step_q, step_d, step_inc;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic [STEP_W-1:0]    fault_step_q, fault_step_d, fault_idx;
    logic                 perst_q, pwr_ok_q, fault_q;
    logic [NUM_RAILS-1:0] step_oh, chk_mask, lost;
    logic                 pg_cur, go_fault, go_down;
    logic                 tmr_clr, tmr_exp;
    logic [TMR_W-1:0]     tmr_load;

    // Rails below the current step are already good; in ON every rail is watched.
    assign step_oh  = RAIL0 << step_q;
    assign chk_mask = (state_q == ST_ON) ? '1 : (step_oh - RAIL0);
    assign lost     = chk_mask & ~pg_in;
    assign pg_cur   = |(pg_in & step_oh);
    assign step_inc = (step_q == LAST_STEP) ? step_q : step_q + STEP_W'(1);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        en_d         = en_q;
        fault_step_d = fault_step_q;
        fault_idx    = lowest_set(lost);
        go_fault     = 1'b0;
        go_down      = 1'b0;
        unique case (state_q)
            ST_OFF: begin
                if (pwr_req) begin
                    state_d = ST_PG_WAIT;
                    step_d  = '0;
                    en_d    = RAIL0;
                end
            end
            ST_PG_WAIT: begin
                if (|lost) begin
                    go_fault = 1'b1;
                end else if (!pg_cur && tmr_exp) begin
                    go_fault  = 1'b1;
                    fault_idx = step_q;
                end else if (!pwr_req) begin
                    go_down = 1'b1;
                end else if (pg_cur) begin
                    state_d = (step_q == LAST_STEP) ? ST_PERST_DLY : ST_ON_DLY;
                end
            end
            ST_ON_DLY: begin
                if (|lost) begin
                    go_fault = 1'b1;
                end else if (!pwr_req) begin
                    go_down = 1'b1;
                end else if (tmr_exp) begin
                    state_d = ST_PG_WAIT;
                    step_d  = step_inc;
                    en_d    = en_q | (RAIL0 << step_inc);
                end
            end
            ST_PERST_DLY: begin
                if (|lost)          go_fault = 1'b1;
                else if (!pwr_req)  go_down  = 1'b1;
                else if (tmr_exp)   state_d  = ST_ON;
            end
            ST_ON: begin
                if (|lost)          go_fault = 1'b1;
                else if (!pwr_req)  go_down  = 1'b1;
            end
            ST_OFF_SEQ: begin
                if (tmr_exp) begin
                    if (en_q == '0) state_d = ST_OFF;
                    else            en_d    = drop_top_rail(en_q);
                end
            end
            ST_FAULT: begin
`ifdef NIC3_PWRSEQ_FAULT_LATCH_EN
                state_d = ST_FAULT;
`else
                if (!pwr_req) state_d = ST_OFF;
`endif
            end
            default: begin
                state_d = ST_OFF;
                en_d    = '0;
            end
        endcase
        if (go_fault) begin
            state_d      = ST_FAULT;
            en_d         = '0;
            fault_step_d = fault_idx;
        end else if (go_down) begin
            state_d = ST_OFF_SEQ;
            en_d    = drop_top_rail(en_q);
        end
    end

    // Each rail drop in OFF_SEQ restarts the timer, as does any state or step change.
    assign tmr_clr = (state_d != state_q) || (step_d != step_q) || (en_d != en_q);

    always_comb begin
        tmr_load = '0;
        unique case (state_d)
            ST_PG_WAIT:   tmr_load = T_PG_TMO;
            ST_ON_DLY:    tmr_load = T_ON_DLY;
            ST_PERST_DLY: tmr_load = T_PERST_DLY;
            ST_OFF_SEQ:   tmr_load = T_OFF_DLY;
            default:      tmr_load = '0;
        endcase
    end

    seq_step_timer u_timer (
        .clk_in    (clk_in),
        .iRst_n    (iRst_n),
        .clr_i     (tmr_clr),
        .load_i    (tmr_load),
        .expired_o (tmr_exp)
    );

    always_ff @(posedge clk_in or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q      <= ST_OFF;
            step_q       <= '0;
            en_q         <= '0;
            fault_step_q <= '0;
            perst_q      <= 1'b0;
            pwr_ok_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            en_q         <= en_d;
            fault_step_q <= fault_step_d;
            perst_q      <= (state_d == ST_ON);
            pwr_ok_q     <= (state_d == ST_ON);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign en_out      = en_q;
    assign perst_n_out = perst_q;
    assign pwr_ok      = pwr_ok_q;
    assign fault       = fault_q;
    assign fault_step  = fault_step_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_nic3_pwr_seq.sv
// Self-checking bench for nic3_pwr_seq: randomized rail timing against cycle arithmetic.
module tb_nic3_pwr_seq;

    localparam int T_PG = 20, T_ON = 10, T_PERST = 50, T_OFF = 5;
    localparam logic [2:0] S_OFF = 3'd0, S_PGW = 3'd1, S_OND = 3'd2, S_PERD = 3'd3,
                           S_ON = 3'd4, S_OFFS = 3'd5, S_FLT = 3'd6;

    logic       clk_in = 1'b0;
    logic       iRst_n = 1'b0;
    logic       pwr_req = 1'b0;
    logic [2:0] pg_in = 3'b000;
    logic [2:0] en_out;
    logic       perst_n_out, pwr_ok, fault;
    logic [1:0] fault_step;
    logic [2:0] state_out;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    nic3_pwr_seq #(
        .T_PG_TMO    (16'd20),
        .T_ON_DLY    (16'd10),
        .T_PERST_DLY (16'd50),
        .T_OFF_DLY   (16'd5)
    ) dut (
        .clk_in      (clk_in),
        .iRst_n      (iRst_n),
        .pwr_req     (pwr_req),
        .pg_in       (pg_in),
        .en_out      (en_out),
        .perst_n_out (perst_n_out),
        .pwr_ok      (pwr_ok),
        .fault       (fault),
        .fault_step  (fault_step),
        .state_out   (state_out)
    );

    function automatic logic [2:0] drop_top(input logic [2:0] p);
        if (p[2]) return p & 3'b011;
        if (p[1]) return p & 3'b101;
        return 3'b000;
    endfunction

    function automatic int lowest(input logic [2:0] m);
        if (m[0]) return 0;
        if (m[1]) return 1;
        return 2;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // sel: 0 en_out, 1 perst_n_out, 2 state_out, 3 fault. at = -1 on timeout.
    task automatic wait_for(input int sel, input logic [2:0] val, input int budget, output int at);
        bit hit;
        at = -1;
        for (int k = 0; k <= budget && at < 0; k++) begin
            hit = (sel == 0 && en_out === val) || (sel == 1 && perst_n_out === val[0]) ||
                  (sel == 2 && state_out === val) || (sel == 3 && fault === val[0]);
            if (hit) at = cyc;
            else @(negedge clk_in);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        iRst_n = 1'b0; pwr_req = 1'b0; pg_in = 3'b000;
        @(negedge clk_in);
        iRst_n = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        iRst_n = 1'b0; pwr_req = 1'b0; pg_in = 3'b000;
        idle(2);
        obs = {en_out, perst_n_out, pwr_ok, fault, fault_step, state_out};
        n_checks++;
        if (obs !== 11'd0) begin n_errors++; $display("FAIL reset_outputs: got %b want 0", obs); end
        iRst_n = 1'b1;
        idle(3);
        n_checks++;
        if (state_out !== S_OFF || en_out !== 3'b000) begin
            n_errors++; $display("FAIL reset_idle: state %0d en %b want OFF 000", state_out, en_out);
        end
    endtask

    task automatic test_power_up(input bit preset, input int fixd);
        int at, pg_edge, d, c;
        logic [2:0] pat;
        if (preset) pg_in = 3'b111;
        pwr_req = 1'b1;
        c = cyc;
        wait_for(0, 3'b001, 4, at);
        n_checks++;
        if (at != c + 1) begin n_errors++; $display("FAIL pu_start: en001 at %0d want %0d", at, c + 1); end
        for (int i = 0; i < 3; i++) begin
            if (preset) begin
                pg_edge = at + 1;
            end else begin
                d = (fixd > 0) ? fixd : int'($urandom_range(1, T_PG - 1));
                idle(d - 1);
                pg_in[i] = 1'b1;
                pg_edge = cyc + 1;
            end
            if (i < 2) begin
                pat = 3'((1 << (i + 2)) - 1);
                wait_for(0, pat, T_PG + T_ON, at);
                n_checks++;
                if (at - pg_edge != T_ON) begin
                    n_errors++; $display("FAIL pu_gap%0d: got %0d want %0d", i, at - pg_edge, T_ON);
                end
            end else begin
                wait_for(1, 3'b001, T_PERST + 5, at);
                n_checks++;
                if (at - pg_edge != T_PERST) begin
                    n_errors++; $display("FAIL pu_perst: got %0d want %0d", at - pg_edge, T_PERST);
                end
                n_checks++;
                if ({pwr_ok, fault, en_out, state_out} !== {1'b1, 1'b0, 3'b111, S_ON}) begin
                    n_errors++;
                    $display("FAIL pu_on: pwr_ok %b fault %b en %b state %0d want 1 0 111 4",
                             pwr_ok, fault, en_out, state_out);
                end
            end
        end
    endtask

    task automatic test_power_down(input logic [2:0] start, input bit from_on);
        int at, c, t;
        logic [2:0] pat;
        pwr_req = 1'b0;
        c = cyc;
        t = c + 1;
        pat = start;
        if (from_on) begin
            wait_for(1, 3'b000, 4, at);
            n_checks++;
            if (at != c + 1) begin n_errors++; $display("FAIL pd_perst: at %0d want %0d", at, c + 1); end
        end
        for (int k = 0; k < 3 && pat != 3'b000; k++) begin
            pat = drop_top(pat);
            wait_for(0, pat, T_OFF + 4, at);
            n_checks++;
            if (at != t) begin n_errors++; $display("FAIL pd_step%0d: en %b at %0d want %0d", k, pat, at, t); end
            t += T_OFF;
        end
        wait_for(2, S_OFF, T_OFF + 4, at);
        n_checks++;
        if (at != t) begin n_errors++; $display("FAIL pd_off: at %0d want %0d", at, t); end
        pg_in = 3'b000;
    endtask

    task automatic test_pg_timeout();
        int r, at, t_en, c, d;
        r = int'($urandom_range(0, 2));
        pwr_req = 1'b1;
        wait_for(0, 3'b001, 4, at);
        t_en = at;
        for (int i = 0; i < r; i++) begin
            d = int'($urandom_range(1, T_PG - 1));
            idle(d - 1);
            pg_in[i] = 1'b1;
            wait_for(0, 3'((1 << (i + 2)) - 1), T_PG + T_ON, at);
            t_en = at;
        end
        wait_for(3, 3'b001, T_PG + 4, at);
        n_checks++;
        if (at - t_en != T_PG) begin n_errors++; $display("FAIL tmo_time: got %0d want %0d", at - t_en, T_PG); end
        n_checks++;
        if (fault_step !== 2'(r)) begin n_errors++; $display("FAIL tmo_step: got %0d want %0d", fault_step, r); end
        n_checks++;
        if ({en_out, perst_n_out, pwr_ok, state_out} !== {3'b000, 1'b0, 1'b0, S_FLT}) begin
            n_errors++;
            $display("FAIL tmo_outs: en %b perst %b ok %b state %0d want 000 0 0 6", en_out, perst_n_out, pwr_ok, state_out);
        end
`ifdef NIC3_PWRSEQ_FAULT_LATCH_EN
        pwr_req = 1'b0; idle(3);
        pwr_req = 1'b1; idle(3);
        pwr_req = 1'b0; idle(3);
        n_checks++;
        if (state_out !== S_FLT || fault !== 1'b1) begin
            n_errors++; $display("FAIL tmo_sticky: state %0d fault %b want 6 1", state_out, fault);
        end
        do_reset();
        n_checks++;
        if (fault !== 1'b0 || fault_step !== 2'd0) begin
            n_errors++; $display("FAIL tmo_rst: fault %b step %0d want 0 0", fault, fault_step);
        end
`else
        pwr_req = 1'b0;
        c = cyc;
        wait_for(2, S_OFF, 4, at);
        n_checks++;
        if (at != c + 1) begin n_errors++; $display("FAIL tmo_exit: at %0d want %0d", at, c + 1); end
        n_checks++;
        if (fault !== 1'b0 || fault_step !== 2'(r)) begin
            n_errors++; $display("FAIL tmo_after: fault %b step %0d want 0 %0d", fault, fault_step, r);
        end
`endif
        pg_in = 3'b000;
    endtask

    task automatic test_rail_loss();
        logic [2:0] mask;
        bit simul;
        int c, at;
        test_power_up(1'b0, 0);
        mask  = 3'($urandom_range(1, 7));
        simul = 1'($urandom_range(0, 1));
        pg_in = 3'b111 & ~mask;
        if (simul) pwr_req = 1'b0;
        c = cyc;
        idle(1);
        pg_in = 3'b111;
        n_checks++;
        if (fault !== 1'b1 || state_out !== S_FLT) begin
            n_errors++; $display("FAIL loss_fault: fault %b state %0d want 1 6 (mask %b)", fault, state_out, mask);
        end
        n_checks++;
        if (fault_step !== 2'(lowest(mask))) begin
            n_errors++; $display("FAIL loss_step: got %0d want %0d", fault_step, lowest(mask));
        end
        n_checks++;
        if ({en_out, perst_n_out, pwr_ok} !== 5'b00000) begin
            n_errors++; $display("FAIL loss_outs: en %b perst %b ok %b want 000 0 0", en_out, perst_n_out, pwr_ok);
        end
`ifdef NIC3_PWRSEQ_FAULT_LATCH_EN
        do_reset();
`else
        pwr_req = 1'b0;
        wait_for(2, S_OFF, 4, at);
        n_checks++;
        if (at != c + 2) begin n_errors++; $display("FAIL loss_exit: at %0d want %0d", at, c + 2); end
`endif
        pg_in = 3'b000;
    endtask

    task automatic test_abort_on_dly();
        int at, at2, d, k, p1, c;
        pwr_req = 1'b1;
        pg_in = 3'b000;
        wait_for(0, 3'b001, 4, at);
        d = int'($urandom_range(1, T_PG - 1));
        idle(d - 1);
        pg_in[0] = 1'b1;
        wait_for(0, 3'b011, T_PG + T_ON, at);
        d = int'($urandom_range(1, T_PG - 1));
        idle(d - 1);
        pg_in[1] = 1'b1;
        p1 = cyc + 1;
        k = int'($urandom_range(0, 8));
        idle(1 + k);
        n_checks++;
        if (state_out !== S_OND) begin n_errors++; $display("FAIL abort_pre: state %0d want 2", state_out); end
        pwr_req = 1'b0;
        c = cyc;
        idle(1);
        pg_in = 3'b000;
        n_checks++;
        if (en_out !== 3'b001 || state_out !== S_OFFS) begin
            n_errors++; $display("FAIL abort_first: en %b state %0d want 001 5", en_out, state_out);
        end
        idle(2);
        pwr_req = 1'b1;
        wait_for(0, 3'b000, T_OFF + 4, at);
        n_checks++;
        if (at != c + 1 + T_OFF) begin n_errors++; $display("FAIL abort_last: at %0d want %0d", at, c + 1 + T_OFF); end
        wait_for(2, S_OFF, T_OFF + 4, at);
        n_checks++;
        if (at != c + 1 + 2 * T_OFF) begin n_errors++; $display("FAIL abort_off: at %0d want %0d", at, c + 1 + 2 * T_OFF); end
        wait_for(0, 3'b001, 4, at);
        n_checks++;
        if (at != c + 2 + 2 * T_OFF || state_out !== S_PGW) begin
            n_errors++; $display("FAIL abort_restart: at %0d state %0d want %0d 1", at, state_out, c + 2 + 2 * T_OFF);
        end
        pwr_req = 1'b0;
        wait_for(2, S_OFF, T_OFF + 6, at2);
        n_checks++;
        if (at2 != at + 1 + T_OFF) begin n_errors++; $display("FAIL abort_down: at %0d want %0d", at2, at + 1 + T_OFF); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] obs;
        int at, c;
        pg_in = 3'b111;
        pwr_req = 1'b1;
        wait_for(2, S_PERD, 40, at);
        idle(int'($urandom_range(0, 40)));
        #2;
        iRst_n = 1'b0;
        #1;
        obs = {en_out, perst_n_out, pwr_ok, fault, fault_step, state_out};
        n_checks++;
        if (at < 0 || obs !== 11'd0) begin n_errors++; $display("FAIL rst_async: got %b want 0 (perst_dly at %0d)", obs, at); end
        @(negedge clk_in);
        pg_in = 3'b000;
        iRst_n = 1'b1;
        c = cyc;
        wait_for(0, 3'b001, 4, at);
        n_checks++;
        if (at != c + 1 || state_out !== S_PGW) begin
            n_errors++; $display("FAIL rst_restart: at %0d state %0d want %0d 1", at, state_out, c + 1);
        end
        idle(3);
        n_checks++;
        if (en_out !== 3'b001) begin n_errors++; $display("FAIL rst_step0: en %b want 001", en_out); end
        test_power_down(3'b001, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) begin
            test_power_up(1'b0, 0);
            test_power_down(3'b111, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_power_up(1'b0, 3);
        test_power_down(3'b111, 1'b1);
        test_power_up(1'b1, 0);
        test_power_down(3'b111, 1'b1);
        test_pg_timeout();
        test_rail_loss();
        test_abort_on_dly();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
